// File: rtl/dct_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dct_sched_pkg                                                              |
// | Shared constants, tag-width helper and issue FSM states for the scheduler. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dct_sched_pkg;

    localparam int BLK_WORDS = 64;

    function automatic int tag_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dct_sched_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dct_sched_tag_fifo                                                         |
// | In-order FIFO of requester tags for blocks currently inside the core.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dct_sched_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_depth) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dct8x8_block_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dct8x8_block_scheduler                                                     |
// | Round-robin sharing of one 8x8 DCT core, results returned in issue order.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dct8x8_block_scheduler
    import dct_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IN_W    = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*BLK_WORDS*IN_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]                   resp_valid,
    input  logic [NUM_REQ-1:0]                   resp_ready,
    output logic [BLK_WORDS*IN_W-1:0]            resp_data,
    output logic                                 dct_in_valid,
    input  logic                                 dct_in_ready,
    output logic [BLK_WORDS*IN_W-1:0]            dct_in_data,
    input  logic                                 dct_out_valid,
    output logic                                 dct_out_ready,
    input  logic [BLK_WORDS*IN_W-1:0]            dct_out_data,
    output logic [$clog2(MAX_OUT):0]             outstanding,
    output logic                                 err_orphan
);
    localparam int BLK_BITS = BLK_WORDS * IN_W;
    localparam int TW       = tag_w(NUM_REQ);
    localparam logic [TW:0]   c_num_req = (TW+1)'(NUM_REQ);
    localparam logic [TW-1:0] c_last    = TW'(NUM_REQ - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_grant;
    logic [TW-1:0]   r_rr_ptr;
    logic            r_err_orphan;
    logic [TW:0]     w_cand;
    logic [TW-1:0]   w_pick;
    logic            w_found;
    logic            w_take;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [TW-1:0]   w_head;
    logic [BLK_BITS-1:0] w_req_blk [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req_unpack
        assign w_req_blk[r] = req_data[r*BLK_BITS +: BLK_BITS];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (TW+1)'(i);
            if (w_cand >= c_num_req) w_cand = w_cand - c_num_req;
            if (!w_found && req_valid[w_cand[TW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[TW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        dct_in_valid = 1'b0;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_full && w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                dct_in_valid       = 1'b1;
                req_ready[r_grant] = dct_in_ready;
                if (dct_in_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dct_in_data = w_req_blk[r_grant];
    assign w_push      = (r_state == S_OFFER) && dct_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) r_grant <= w_pick;
            if (w_push) r_rr_ptr <= (r_grant == c_last) ? '0 : r_grant + 1'b1;
            if (w_fifo_empty && dct_out_valid) r_err_orphan <= 1'b1;
        end
    end

    // With no tag outstanding the core is drained and its output discarded.
    always_comb begin
        resp_valid    = '0;
        dct_out_ready = 1'b1;
        if (!w_fifo_empty) begin
            resp_valid[w_head] = dct_out_valid;
            dct_out_ready      = resp_ready[w_head];
        end
    end

    assign w_pop      = dct_out_valid && dct_out_ready && !w_fifo_empty;
    assign resp_data  = dct_out_data;
    assign err_orphan = r_err_orphan;

    dct_sched_tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (TW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_grant),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (outstanding)
    );

endmodule
`default_nettype wire

// File: tb/tb_dct8x8_block_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dct8x8_block_scheduler                                                  |
// | Directed self-checking bench; the bench itself plays the DCT core.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dct8x8_block_scheduler;
    localparam int NR = 3;
    localparam int BB = 64 * 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*BB-1:0] req_data;
    logic [NR-1:0] resp_valid;
    logic [NR-1:0] resp_ready;
    logic [BB-1:0] resp_data;
    logic          dct_in_valid;
    logic          dct_in_ready;
    logic [BB-1:0] dct_in_data;
    logic          dct_out_valid;
    logic          dct_out_ready;
    logic [BB-1:0] dct_out_data;
    logic [2:0]    outstanding;
    logic          err_orphan;

    int checks = 0;
    int errors = 0;
    int rem [NR];
    logic [BB-1:0] blk [NR];

    dct8x8_block_scheduler #(.NUM_REQ(NR), .IN_W(32), .MAX_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .dct_in_valid(dct_in_valid), .dct_in_ready(dct_in_ready), .dct_in_data(dct_in_data),
        .dct_out_valid(dct_out_valid), .dct_out_ready(dct_out_ready), .dct_out_data(dct_out_data),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req_valid = '0; resp_ready = '0; dct_in_ready = 1'b0;
        dct_out_valid = 1'b0; dct_out_data = '0;
        for (int r = 0; r < NR; r++) rem[r] = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drives requesters from rem[] until target handshakes or the cycle budget runs out.
    task automatic issue(input int max_cyc, input int target, output int got);
        logic hs;
        logic [NR-1:0] hv;
        got = 0;
        for (int c = 0; c < max_cyc && got < target; c++) begin
            for (int r = 0; r < NR; r++) req_valid[r] = (rem[r] != 0);
            #1;
            hs = dct_in_valid && dct_in_ready;
            hv = req_ready;
            tick();
            if (hs) begin
                got++;
                for (int r = 0; r < NR; r++) if (hv[r]) rem[r]--;
            end
        end
        for (int r = 0; r < NR; r++) req_valid[r] = (rem[r] != 0);
    endtask

    task automatic test_reset;
        apply_reset();
        #1;
        checks++; if (dct_in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got=%b exp=0", dct_in_valid); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready got=%b exp=000", req_ready); end
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL rst_resp_valid got=%b exp=000", resp_valid); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rst_err_orphan got=%b exp=0", err_orphan); end
    endtask

    task automatic test_single;
        logic [BB-1:0] res;
        res = {64{32'h0008_0000}};
        dct_in_ready = 1'b1;
        req_valid = 3'b001;
        #1;
        checks++; if (dct_in_valid !== 1'b0) begin errors++; $display("FAIL single_no_comb got=%b exp=0", dct_in_valid); end
        tick();
        checks++; if (dct_in_valid !== 1'b1 || req_ready !== 3'b001) begin errors++; $display("FAIL single_offer got=%b/%b exp=1/001", dct_in_valid, req_ready); end
        checks++; if (dct_in_data !== blk[0]) begin errors++; $display("FAIL single_in_data got=%h exp=%h", dct_in_data[31:0], blk[0][31:0]); end
        tick();
        req_valid = 3'b000;
        #1;
        checks++; if (outstanding !== 3'd1 || dct_in_valid !== 1'b0) begin errors++; $display("FAIL single_issued got=%0d/%b exp=1/0", outstanding, dct_in_valid); end
        dct_out_valid = 1'b1; dct_out_data = res; resp_ready = 3'b001;
        #1;
        checks++; if (resp_valid !== 3'b001 || dct_out_ready !== 1'b1) begin errors++; $display("FAIL single_resp got=%b/%b exp=001/1", resp_valid, dct_out_ready); end
        checks++; if (resp_data !== res) begin errors++; $display("FAIL single_resp_data got=%h exp=%h", resp_data[31:0], res[31:0]); end
        tick();
        dct_out_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0 || resp_valid !== 3'b000) begin errors++; $display("FAIL single_drained got=%0d/%b exp=0/000", outstanding, resp_valid); end
    endtask

    task automatic test_fairness;
        int issued;
        int returned;
        int gcnt [NR];
        logic hs, rt;
        logic [NR-1:0] hv, exp;
        apply_reset();
        issued = 0; returned = 0;
        for (int r = 0; r < NR; r++) begin rem[r] = 6; gcnt[r] = 0; end
        resp_ready = 3'b111; dct_in_ready = 1'b1;
        for (int c = 0; c < 300 && (issued < 18 || returned < 18); c++) begin
            for (int r = 0; r < NR; r++) req_valid[r] = (rem[r] != 0);
            dct_out_valid = (issued > returned);
            dct_out_data = {64{32'hA000_0000 + 32'(returned)}};
            #1;
            hs = dct_in_valid && dct_in_ready;
            hv = req_ready;
            if (hs) begin
                exp = 3'b001 << (issued % 3);
                checks++; if (hv !== exp) begin errors++; $display("FAIL fair_grant n=%0d got=%b exp=%b", issued, hv, exp); end
            end
            rt = dct_out_valid && dct_out_ready;
            if (dct_out_valid) begin
                exp = 3'b001 << (returned % 3);
                checks++; if (resp_valid !== exp) begin errors++; $display("FAIL fair_return n=%0d got=%b exp=%b", returned, resp_valid, exp); end
            end
            tick();
            if (hs) begin
                issued++;
                for (int r = 0; r < NR; r++) if (hv[r]) begin rem[r]--; gcnt[r]++; end
            end
            if (rt) returned++;
        end
        dct_out_valid = 1'b0; req_valid = '0;
        checks++; if (issued != 18 || returned != 18) begin errors++; $display("FAIL fair_totals got=%0d/%0d exp=18/18", issued, returned); end
        for (int r = 0; r < NR; r++) begin
            checks++; if (gcnt[r] != 6) begin errors++; $display("FAIL fair_count r=%0d got=%0d exp=6", r, gcnt[r]); end
        end
    endtask

    task automatic test_full_fifo;
        int got;
        apply_reset();
        rem[1] = 5; dct_in_ready = 1'b1; resp_ready = 3'b111;
        issue(30, 5, got);
        checks++; if (got != 4) begin errors++; $display("FAIL full_issued got=%0d exp=4", got); end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (outstanding !== 3'd4 || req_ready !== 3'b000 || dct_in_valid !== 1'b0) begin
                errors++; $display("FAIL full_stall got=%0d/%b/%b exp=4/000/0", outstanding, req_ready, dct_in_valid); end
            tick();
        end
        dct_out_valid = 1'b1; dct_out_data = {64{32'h0000_00F1}};
        #1;
        checks++; if (resp_valid !== 3'b010) begin errors++; $display("FAIL full_release got=%b exp=010", resp_valid); end
        tick();
        dct_out_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3 || dct_in_valid !== 1'b0) begin errors++; $display("FAIL full_after_pop got=%0d/%b exp=3/0", outstanding, dct_in_valid); end
        tick();
        checks++; if (dct_in_valid !== 1'b1 || req_ready !== 3'b010) begin errors++; $display("FAIL full_fifth got=%b/%b exp=1/010", dct_in_valid, req_ready); end
        tick();
        rem[1] = 0; req_valid = '0;
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", outstanding); end
        dct_out_valid = 1'b1;
        repeat (4) tick();
        dct_out_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", outstanding); end
    endtask

    task automatic test_backpressure;
        int got;
        logic [BB-1:0] r1, r2;
        r1 = {64{32'h0000_0111}};
        r2 = {64{32'h0000_0222}};
        apply_reset();
        rem[1] = 1; rem[2] = 1; dct_in_ready = 1'b1;
        issue(20, 2, got);
        checks++; if (got != 2 || outstanding !== 3'd2) begin errors++; $display("FAIL bp_issue got=%0d/%0d exp=2/2", got, outstanding); end
        resp_ready = 3'b101; dct_out_valid = 1'b1; dct_out_data = r1;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (dct_out_ready !== 1'b0 || resp_valid !== 3'b010) begin
                errors++; $display("FAIL bp_stall c=%0d got=%b/%b exp=0/010", c, dct_out_ready, resp_valid); end
            tick();
        end
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL bp_held got=%0d exp=2", outstanding); end
        resp_ready = 3'b111;
        #1;
        checks++; if (dct_out_ready !== 1'b1 || resp_valid !== 3'b010 || resp_data !== r1) begin
            errors++; $display("FAIL bp_first got=%b/%b exp=1/010", dct_out_ready, resp_valid); end
        tick();
        dct_out_data = r2;
        #1;
        checks++; if (resp_valid !== 3'b100 || resp_data !== r2) begin errors++; $display("FAIL bp_second got=%b exp=100", resp_valid); end
        tick();
        dct_out_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_drain got=%0d exp=0", outstanding); end
    endtask

    task automatic test_orphan;
        dct_out_valid = 1'b1; dct_out_data = {64{32'hDEAD_0000}};
        #1;
        checks++; if (resp_valid !== 3'b000 || dct_out_ready !== 1'b1) begin errors++; $display("FAIL orphan_drain got=%b/%b exp=000/1", resp_valid, dct_out_ready); end
        tick();
        dct_out_valid = 1'b0;
        #1;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
        repeat (3) tick();
        checks++; if (err_orphan !== 1'b1 || resp_valid !== 3'b000) begin errors++; $display("FAIL orphan_sticky got=%b/%b exp=1/000", err_orphan, resp_valid); end
    endtask

    task automatic test_reset_mid;
        int got;
        rem[0] = 2; dct_in_ready = 1'b1;
        issue(20, 2, got);
        checks++; if (got != 2 || outstanding !== 3'd2) begin errors++; $display("FAIL mid_issue got=%0d/%0d exp=2/2", got, outstanding); end
        dct_in_ready = 1'b0; rem[1] = 1; req_valid = 3'b010;
        tick();
        checks++; if (dct_in_valid !== 1'b1) begin errors++; $display("FAIL mid_offer got=%b exp=1", dct_in_valid); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (dct_in_valid !== 1'b0 || outstanding !== 3'd0 || err_orphan !== 1'b0) begin
            errors++; $display("FAIL mid_async got=%b/%0d/%b exp=0/0/0", dct_in_valid, outstanding, err_orphan); end
        #2 rst_n = 1'b1;
        dct_in_ready = 1'b1;
        tick();
        checks++; if (dct_in_valid !== 1'b1 || req_ready !== 3'b010 || dct_in_data !== blk[1]) begin
            errors++; $display("FAIL mid_resume got=%b/%b exp=1/010", dct_in_valid, req_ready); end
        tick();
        rem[1] = 0; req_valid = '0;
        #1;
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL mid_issued got=%0d exp=1", outstanding); end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            blk[r] = {64{32'h0001_0000 + 32'(r)}};
            req_data[r*BB +: BB] = blk[r];
        end
        test_reset();
        test_single();
        test_fairness();
        test_full_fifo();
        test_backpressure();
        test_orphan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
